// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared encodings for the data-memory request/response path.
//            The memory-op and access-size codes are also consumed by the
//            downstream load formatter, so both sides import them from here.
//            Also holds the request controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Memory operation requested by the execute stage
    localparam logic [1:0] MEM_DISABLE   = 2'b00;
    localparam logic [1:0] MEM_READ_SEXT = 2'b01;
    localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
    localparam logic [1:0] MEM_WRITE     = 2'b11;

    // Access size; 2'b11 is not a legal size
    localparam logic [1:0] MEM_BYTE      = 2'b00;
    localparam logic [1:0] MEM_HALFWORD  = 2'b01;
    localparam logic [1:0] MEM_WORD      = 2'b10;

    // Request controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_RESP = 2'b10,
        S_ERR  = 2'b11
    } memState_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_lane_pack.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_pack
// Purpose  : Combinational store-lane builder. Replicates store data across
//            the byte lanes of a 32-bit little-endian word, derives the byte
//            strobes from size and address offset, and flags misalignment.
// Ports    : size       in  2   access size (BYTE/HALFWORD/WORD/illegal)
//            addrLo     in  2   byte offset within the word
//            data       in  32  raw store data (rs2)
//            wdata      out 32  lane-replicated write data
//            wstrb      out 4   byte enables for the access
//            misaligned out 1   illegal size or offset not a size multiple
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_pack (
    input  logic [1:0]  size,
    input  logic [1:0]  addrLo,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        misaligned
);
    import mem_pkg::*;

    always_comb begin
        wdata      = '0;
        wstrb      = '0;
        misaligned = 1'b0;
        case (size)
            MEM_BYTE: begin
                wdata = {4{data[7:0]}};
                wstrb = 4'b0001 << addrLo;
            end
            MEM_HALFWORD: begin
                wdata      = {2{data[15:0]}};
                wstrb      = 4'b0011 << addrLo;
                misaligned = addrLo[0];
            end
            MEM_WORD: begin
                wdata      = data;
                wstrb      = 4'b1111;
                misaligned = (addrLo != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule : mem_lane_pack
`default_nettype wire

// File: rtl/mem_store_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_store_ctrl
// Purpose  : Request side of the data-memory interface. Accepts an op from
//            execute, checks alignment, builds word address / lane data /
//            strobes, runs a req/ack handshake with memory and holds the op
//            context for the response formatter.
// Ports    : clk, rst_n                      clock, async active-low reset
//            in_valid/in_ready               op handshake from execute
//            mem_op, mem_size, addr,
//            store_data                      op description
//            mem_req, mem_we, mem_addr,
//            mem_wdata, mem_wstrb, mem_ack   data-memory request interface
//            rsp_op, rsp_size, rsp_addr_lo   latched context for formatter
//            request_done                    1-cycle completion pulse
//            misalign_err, timeout_err       1-cycle error pulses
// Revision : 1.0 - initial release
// ============================================================================
module mem_store_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  mem_op,
    input  logic [1:0]  mem_size,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    output logic [1:0]  rsp_op,
    output logic [1:0]  rsp_size,
    output logic [1:0]  rsp_addr_lo,
    output logic        request_done,
    output logic        misalign_err,
    output logic        timeout_err
);
    import mem_pkg::*;

    // Count value at which an unacknowledged REQ cycle aborts
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    memState_t   r_state;
    memState_t   w_stateNext;
    logic        w_accept;
    logic        w_timeout;
    logic        w_isWrite;
    logic [31:0] w_packWdata;
    logic [3:0]  w_packWstrb;
    logic        w_misaligned;

    logic [CNT_W-1:0] r_timeoutCnt;
    logic             r_timeoutErr;
    logic             r_memWe;
    logic [31:0]      r_memAddr;
    logic [31:0]      r_memWdata;
    logic [3:0]       r_memWstrb;
    logic [1:0]       r_rspOp;
    logic [1:0]       r_rspSize;
    logic [1:0]       r_rspAddrLo;

    mem_lane_pack u_lanePack (
        .size       (mem_size),
        .addrLo     (addr[1:0]),
        .data       (store_data),
        .wdata      (w_packWdata),
        .wstrb      (w_packWstrb),
        .misaligned (w_misaligned)
    );

    assign w_isWrite = (mem_op == MEM_WRITE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // DISABLE ops are consumed without leaving IDLE
                if (in_valid && (mem_op != MEM_DISABLE)) begin
                    w_accept    = 1'b1;
                    w_stateNext = w_misaligned ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    w_stateNext = S_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (r_timeoutCnt == c_CNT_LAST)) begin
                    w_timeout   = 1'b1;
                    w_stateNext = S_IDLE;
                end
            end
            S_RESP:  w_stateNext = S_IDLE;
            S_ERR:   w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Ack-wait counter and timeout pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeoutCnt <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_timeoutErr <= w_timeout;
            if (w_accept) begin
                r_timeoutCnt <= '0;
            end else if ((r_state == S_REQ) && !mem_ack) begin
                r_timeoutCnt <= r_timeoutCnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request and response context, captured only on accept so it stays
    // stable through REQ/RESP and until the next op.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_memWstrb  <= '0;
            r_rspOp     <= '0;
            r_rspSize   <= '0;
            r_rspAddrLo <= '0;
        end else if (w_accept) begin
            r_memWe     <= w_isWrite;
            r_memAddr   <= {addr[31:2], 2'b00};
            r_memWdata  <= w_isWrite ? w_packWdata : 32'd0;
            r_memWstrb  <= w_isWrite ? w_packWstrb : 4'd0;
            r_rspOp     <= mem_op;
            r_rspSize   <= mem_size;
            r_rspAddrLo <= addr[1:0];
        end
    end

    // Handshake outputs decode straight from the state register so that
    // an asynchronous reset drops mem_req immediately.
    assign in_ready     = (r_state == S_IDLE);
    assign mem_req      = (r_state == S_REQ);
    assign request_done = (r_state == S_RESP);
    assign misalign_err = (r_state == S_ERR);
    assign timeout_err  = r_timeoutErr;

    assign mem_we       = r_memWe;
    assign mem_addr     = r_memAddr;
    assign mem_wdata    = r_memWdata;
    assign mem_wstrb    = r_memWstrb;
    assign rsp_op       = r_rspOp;
    assign rsp_size     = r_rspSize;
    assign rsp_addr_lo  = r_rspAddrLo;

endmodule : mem_store_ctrl
`default_nettype wire

// File: tb/tb_mem_store_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_store_ctrl
// Purpose  : Self-checking bench for mem_store_ctrl. Directed ops from the
//            test plan followed by randomized ops, compared cycle by cycle
//            against a byte-lane reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_store_ctrl;

    localparam int c_TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mem_op;
    logic [1:0]  mem_size;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [1:0]  rsp_op;
    logic [1:0]  rsp_size;
    logic [1:0]  rsp_addr_lo;
    logic        request_done;
    logic        misalign_err;
    logic        timeout_err;

    int nChecks = 0;
    int nErrors = 0;

    // Context the formatter should currently see
    logic [1:0] lastOp   = 2'b00;
    logic [1:0] lastSize = 2'b00;
    logic [1:0] lastLo   = 2'b00;

    mem_store_ctrl #(
        .TIMEOUT_CYCLES (c_TMO),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_op       (mem_op),
        .mem_size     (mem_size),
        .addr         (addr),
        .store_data   (store_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ack      (mem_ack),
        .rsp_op       (rsp_op),
        .rsp_size     (rsp_size),
        .rsp_addr_lo  (rsp_addr_lo),
        .request_done (request_done),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a lane is enabled when it falls inside [lo, lo+bytes)
    function automatic logic [3:0] refStrb(input logic [1:0] op, input logic [1:0] sz,
                                           input logic [1:0] lo);
        int n = 1 << sz;
        refStrb = 4'd0;
        if (op == 2'b11)
            for (int i = 0; i < 4; i++)
                if (i >= int'(lo) && i < int'(lo) + n) refStrb[i] = 1'b1;
    endfunction

    // Reference: lane i carries data byte (i mod size-in-bytes)
    function automatic logic [31:0] refData(input logic [1:0] op, input logic [1:0] sz,
                                            input logic [31:0] d);
        int n = 1 << sz;
        refData = 32'd0;
        if (op == 2'b11)
            for (int i = 0; i < 4; i++) refData[8*i +: 8] = d[8*(i % n) +: 8];
    endfunction

    // Present one op and follow it until in_ready returns.
    // ackWait = REQ cycles without ack before the acking cycle; <0 = never.
    task automatic runOp(input logic [1:0] op, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d, input int ackWait);
        bit mis;
        bit tmo;
        int lastReq;
        int endC;
        mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        tmo = !mis && (ackWait < 0 || ackWait >= c_TMO);
        lastReq = tmo ? c_TMO : ackWait + 1;
        endC = mis ? 2 : (tmo ? c_TMO + 1 : ackWait + 3);

        in_valid   = 1'b1;
        mem_op     = op;
        mem_size   = sz;
        addr       = a;
        store_data = d;
        mem_ack    = 1'($urandom_range(0, 1));  // ack while idle must be ignored
        @(negedge clk);
        checkVal("ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        addr       = $urandom;
        store_data = $urandom;
        mem_size   = 2'($urandom_range(0, 3));
        lastOp = op; lastSize = sz; lastLo = a[1:0];

        for (int c = 1; c <= endC; c++) begin
            if (!mis && !tmo && c == ackWait + 1) mem_ack = 1'b1;
            else if (mis || c > lastReq)          mem_ack = 1'($urandom_range(0, 1));
            else                                  mem_ack = 1'b0;
            @(negedge clk);
            checkVal("mem_req", 32'(mem_req), 32'(!mis && c <= lastReq));
            checkVal("request_done", 32'(request_done), 32'(!mis && !tmo && c == ackWait + 2));
            checkVal("misalign_err", 32'(misalign_err), 32'(mis && c == 1));
            checkVal("timeout_err", 32'(timeout_err), 32'(tmo && c == c_TMO + 1));
            checkVal("in_ready", 32'(in_ready), 32'(c >= endC));
            checkVal("rsp_op", 32'(rsp_op), 32'(op));
            checkVal("rsp_size", 32'(rsp_size), 32'(sz));
            checkVal("rsp_addr_lo", 32'(rsp_addr_lo), 32'(a[1:0]));
            if (!mis && c <= lastReq) begin
                checkVal("mem_we", 32'(mem_we), 32'(op == 2'b11));
                checkVal("mem_addr", mem_addr, {a[31:2], 2'b00});
                checkVal("mem_wdata", mem_wdata, refData(op, sz, d));
                checkVal("mem_wstrb", 32'(mem_wstrb), 32'(refStrb(op, sz, a[1:0])));
            end
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    // DISABLE with valid is swallowed: stay idle, context unchanged
    task automatic runDisable();
        in_valid = 1'b1;
        mem_op   = 2'b00;
        mem_size = 2'($urandom_range(0, 3));
        addr     = $urandom;
        @(negedge clk);
        checkVal("ready_disable", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkVal("disable_ready_after", 32'(in_ready), 32'd1);
        checkVal("disable_no_req", 32'(mem_req), 32'd0);
        checkVal("disable_rsp_op", 32'(rsp_op), 32'(lastOp));
        checkVal("disable_rsp_lo", 32'(rsp_addr_lo), 32'(lastLo));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; mem_op = 2'b00; mem_size = 2'b00;
        addr = 32'd0; store_data = 32'd0; mem_ack = 1'b0;
        #2;
        checkVal("rst_mem_req", 32'(mem_req), 32'd0);
        checkVal("rst_done", 32'(request_done), 32'd0);
        checkVal("rst_misalign", 32'(misalign_err), 32'd0);
        checkVal("rst_timeout", 32'(timeout_err), 32'd0);
        checkVal("rst_mem_addr", mem_addr, 32'd0);
        checkVal("rst_wstrb", 32'(mem_wstrb), 32'd0);
        checkVal("rst_rsp_op", 32'(rsp_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkVal("ready_after_rst", 32'(in_ready), 32'd1);

        // Directed ops from the test plan
        runOp(2'b11, 2'b00, 32'h0000_1003, 32'hAABB_CCDD, 2);   // store byte
        runOp(2'b11, 2'b01, 32'h0000_2002, 32'h1234_5678, 0);   // store half
        runOp(2'b01, 2'b10, 32'h0000_3000, 32'hDEAD_BEEF, 1);   // load word
        runOp(2'b11, 2'b10, 32'h0000_4001, 32'h1111_2222, 0);   // misaligned word
        runOp(2'b10, 2'b11, 32'h0000_4000, 32'h3333_4444, 0);   // illegal size
        runOp(2'b11, 2'b10, 32'h0000_5000, 32'h5555_6666, -1);  // timeout
        runDisable();

        // Reset during REQ
        in_valid = 1'b1; mem_op = 2'b11; mem_size = 2'b10;
        addr = 32'h0000_0040; store_data = 32'hCAFE_F00D; mem_ack = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkVal("pre_rst_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("async_rst_req", 32'(mem_req), 32'd0);
        checkVal("async_rst_done", 32'(request_done), 32'd0);
        checkVal("async_rst_rsp_op", 32'(rsp_op), 32'd0);
        checkVal("async_rst_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        checkVal("rst_hold_misalign", 32'(misalign_err), 32'd0);
        checkVal("rst_hold_timeout", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lastOp = 2'b00; lastSize = 2'b00; lastLo = 2'b00;
        @(posedge clk);
        #1;
        runOp(2'b11, 2'b10, 32'h0000_0010, $urandom, 0);

        // Randomized ops
        for (int k = 0; k < 80; k++) begin
            int w;
            int idle;
            logic [1:0] op;
            op = 2'($urandom_range(1, 3));
            w  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 2));
            runOp(op, 2'($urandom_range(0, 3)), $urandom, $urandom, w);
            if ($urandom_range(0, 4) == 0) runDisable();
            idle = int'($urandom_range(0, 2));
            for (int j = 0; j < idle; j++) begin
                @(posedge clk);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule : tb_mem_store_ctrl
`default_nettype wire
